// File: rtl/perip_pwm_multi_pkg.sv
// perip_pwm_multi_pkg: register map, CTRL bit positions and timebase state type
package perip_pwm_multi_pkg;
  localparam logic [4:0] A_CTRL     = 5'h00;
  localparam logic [4:0] A_PERIOD   = 5'h01;
  localparam logic [4:0] A_PRESCALE = 5'h02;
  localparam logic [4:0] A_STATUS   = 5'h03;
  localparam logic [4:0] A_DUTY     = 5'h10;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_FADE = 1;
  typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/perip_pwm_multi_channel.sv
// pwm_channel: duty shadow, active duty (optionally faded when PWM_FADE_EN is defined) and comparator
module pwm_channel #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [CW-1:0] i_wdata,
  input  logic          i_load,
  input  logic          i_wrap,
  input  logic          i_run,
`ifdef PWM_FADE_EN
  input  logic          i_fade,
`endif
  input  logic [CW-1:0] i_cnt,
  output logic          o_pwm,
  output logic          o_busy,
  output logic [CW-1:0] o_duty
);
  logic [CW-1:0] r_sh, r_act, w_next;
  logic r_pwm;
`ifdef PWM_FADE_EN
  // fading walks the active duty one count per wrap toward the target
  assign w_next = !i_fade ? r_sh : (r_act < r_sh) ? r_act + 1'b1 : (r_act > r_sh) ? r_act - 1'b1 : r_act;
  assign o_busy = r_act != r_sh;
`else
  assign w_next = r_sh;
  assign o_busy = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh  <= '0;
      r_act <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_we) r_sh <= i_wdata;
      if (i_load) r_act <= r_sh;
      else if (i_wrap) r_act <= w_next;
      r_pwm <= i_run && (i_cnt < r_act);
    end
  end
  assign o_pwm  = r_pwm;
  assign o_duty = r_sh;
endmodule

// File: rtl/perip_pwm_multi.sv
// perip_pwm_multi: multi-channel PWM with shared timebase and CPU register bus
// Optional duty fading is built only when PWM_FADE_EN is defined.
module perip_pwm_multi
  import perip_pwm_multi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    d_in,
  input  logic           cs,
  input  logic [31:0]    addr,
  input  logic           rd,
  input  logic           wr,
  output logic [31:0]    d_out,
  output logic [NCH-1:0] pwm
);
  logic [4:0] w_a;
  logic w_we, w_re, w_run, w_enter, w_tick, w_wrap, w_unused;
  logic r_en;
  logic [CW-1:0] r_period, r_period_act, r_cnt;
  logic [15:0] r_prescale, r_pre;
  logic [31:0] r_dout, w_rdata, w_ctrl;
  logic [CW-1:0] w_duty [16];
  logic [NCH-1:0] w_busy;
  state_t r_state, w_state_nx;
  assign w_a      = addr[4:0];
  assign w_we     = cs && wr;
  assign w_re     = cs && rd;
  assign w_unused = ^{d_in, addr};
`ifdef PWM_FADE_EN
  logic r_fade;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fade <= 1'b0;
    else if (w_we && w_a == A_CTRL) r_fade <= d_in[CTRL_FADE];
  end
  assign w_ctrl = {30'd0, r_fade, r_en};
`else
  assign w_ctrl = {31'd0, r_en};
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end
  always_comb w_state_nx = r_en ? S_RUN : S_IDLE;
  assign w_run   = r_state == S_RUN;
  assign w_enter = r_state == S_IDLE && w_state_nx == S_RUN;
  assign w_tick  = w_run && r_pre >= r_prescale;
  assign w_wrap  = w_tick && r_cnt >= r_period_act;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en         <= 1'b0;
      r_period     <= '0;
      r_period_act <= '0;
      r_prescale   <= '0;
      r_pre        <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
    end else begin
      if (w_we && w_a == A_CTRL) r_en <= d_in[CTRL_EN];
      if (w_we && w_a == A_PERIOD) r_period <= d_in[CW-1:0];
      if (w_we && w_a == A_PRESCALE) r_prescale <= d_in[15:0];
      if (w_enter || w_wrap) r_period_act <= r_period;
      if (!w_run) begin
        r_pre <= '0;
        r_cnt <= '0;
      end else begin
        r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
      if (w_re) r_dout <= w_rdata;
    end
  end
  assign w_rdata = (w_a == A_CTRL)     ? w_ctrl :
                   (w_a == A_PERIOD)   ? 32'(r_period) :
                   (w_a == A_PRESCALE) ? 32'(r_prescale) :
                   (w_a == A_STATUS)   ? 32'(w_busy) :
                   w_a[4]              ? 32'(w_duty[w_a[3:0]]) : 32'd0;
  assign d_out = r_dout;
  for (genvar g = 0; g < 16; g++) begin : g_ch
    if (g < NCH) begin : g_on
      pwm_channel #(.CW(CW)) u_ch (
        .clk    (clk),
        .reset  (reset),
        .i_we   (w_we && w_a == (A_DUTY | 5'(g))),
        .i_wdata(d_in[CW-1:0]),
        .i_load (w_enter),
        .i_wrap (w_wrap),
        .i_run  (w_run),
`ifdef PWM_FADE_EN
        .i_fade (r_fade),
`endif
        .i_cnt  (r_cnt),
        .o_pwm  (pwm[g]),
        .o_busy (w_busy[g]),
        .o_duty (w_duty[g])
      );
    end else begin : g_off
      assign w_duty[g] = '0;
    end
  end
endmodule

// File: tb/tb_perip_pwm_multi.sv
// tb_perip_pwm_multi: randomized and directed checks against a duty/period arithmetic model
module tb_perip_pwm_multi;
  localparam int NCH = 4;
  localparam int CW  = 16;
  logic clk = 0, reset = 0, cs = 0, rd = 0, wr = 0;
  logic [31:0] d_in = 0, addr = 0, d_out, v, w;
  logic [NCH-1:0] pwm;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  perip_pwm_multi #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out), .pwm(pwm)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1; wr = 1; addr = $urandom(); addr[4:0] = a; d_in = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask
  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1; rd = 1; addr = $urandom(); addr[4:0] = a;
    @(negedge clk);
    cs = 0; rd = 0;
    d = d_out;
  endtask
  task automatic count_hi(input int ch, input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(pwm[ch]);
    end
  endtask
  // any window of one full PWM period holds min(duty, period+1) high counts, each stretched by the prescale
  function automatic int exp_hi(input int p, input int s, input int d, input int k);
    return ((d > p + 1) ? p + 1 : d) * (s + 1) * k;
  endfunction
  initial begin
    int h, h0, h1, p, s, ch;
    int d [NCH];
    logic prev, found;
    logic [31:0] m;
    m = (32'd1 << CW) - 1;
    reset = 1;
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 0);
    check("reset_dout", d_out, 0);
    reset = 0;
    rd_reg(5'h00, v); check("rst_ctrl", v, 0);
    rd_reg(5'h01, v); check("rst_period", v, 0);
    rd_reg(5'h02, v); check("rst_prescale", v, 0);
    rd_reg(5'h03, v); check("rst_status", v, 0);
    rd_reg(5'h10, v); check("rst_duty0", v, 0);
    wr_reg(5'h01, 9); wr_reg(5'h02, 0); wr_reg(5'h10, 3); wr_reg(5'h00, 1);
    repeat (5) @(negedge clk);
    count_hi(0, 30, h); check("duty3_p9", h, exp_hi(9, 0, 3, 3));
    rd_reg(5'h00, v); check("ctrl_en", v, 1);
    wr_reg(5'h10, 0); repeat (15) @(negedge clk);
    count_hi(0, 20, h); check("duty0_low", h, 0);
    wr_reg(5'h10, 12); repeat (15) @(negedge clk);
    count_hi(0, 20, h); check("duty12_high", h, 20);
    rd_reg(5'h01, v); check("rd_period", v, 9);
    repeat (3) @(negedge clk);
    check("dout_hold", d_out, 9);
    rd_reg(5'h07, v); check("rd_undecoded", v, 0);
    wr_reg(5'h11, 5); repeat (15) @(negedge clk);
    prev = pwm[1]; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (!prev && pwm[1]) found = 1;
      prev = pwm[1];
    end
    check("period_start_found", 32'(found), 1);
    h0 = 1; h1 = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i < 10) h0 += int'(pwm[1]);
      else h1 += int'(pwm[1]);
      if (i == 1) begin cs = 1; wr = 1; addr = 32'h11; d_in = 2; end
      if (i == 2) begin cs = 0; wr = 0; end
    end
    check("midwrite_cur", h0, 5);
    check("midwrite_next", h1, 2);
`ifdef PWM_FADE_EN
    wr_reg(5'h00, 0); wr_reg(5'h10, 0); wr_reg(5'h00, 1); wr_reg(5'h00, 3);
    wr_reg(5'h10, 4);
    rd_reg(5'h03, v); check("fade_busy0", v & 1, 1);
    repeat (20) @(negedge clk);
    rd_reg(5'h03, v); check("fade_busy1", v & 1, 1);
    repeat (25) @(negedge clk);
    rd_reg(5'h03, v); check("fade_done", v, 0);
    count_hi(0, 10, h); check("fade_duty4", h, 4);
    wr_reg(5'h00, 1);
`else
    wr_reg(5'h00, 3);
    rd_reg(5'h00, v); check("fade_ignored", v, 1);
    rd_reg(5'h03, v); check("status_zero", v, 0);
    wr_reg(5'h00, 1);
`endif
    wr_reg(5'h00, 0);
    for (int i = 0; i < 4; i++) begin
      v = $urandom(); wr_reg(5'h01, v); rd_reg(5'h01, w); check("rb_period", w, v & m);
      v = $urandom(); wr_reg(5'h02, v); rd_reg(5'h02, w); check("rb_prescale", w, v & 32'hFFFF);
      ch = $urandom_range(0, NCH - 1);
      v = $urandom(); wr_reg(5'(16 + ch), v); rd_reg(5'(16 + ch), w); check("rb_duty", w, v & m);
    end
    if (NCH < 16) begin
      wr_reg(5'(16 + NCH), 32'h55); rd_reg(5'(16 + NCH), w); check("rb_bad_chan", w, 0);
    end
    for (int it = 0; it < 5; it++) begin
      wr_reg(5'h00, 0);
      p = $urandom_range(2, 12);
      s = $urandom_range(0, 2);
      wr_reg(5'h01, p); wr_reg(5'h02, s);
      for (int c = 0; c < NCH; c++) begin
        d[c] = $urandom_range(0, p + 3);
        wr_reg(5'(16 + c), d[c]);
      end
      wr_reg(5'h00, 1);
      repeat (4) @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        count_hi(c, (p + 1) * (s + 1), h);
        check($sformatf("rand_it%0d_ch%0d", it, c), h, exp_hi(p, s, d[c], 1));
      end
    end
    wr_reg(5'h00, 0); wr_reg(5'h01, 9); wr_reg(5'h02, 0); wr_reg(5'h10, 12); wr_reg(5'h00, 1);
    repeat (5) @(negedge clk);
    check("pre_reset_high", 32'(pwm[0]), 1);
    #2 reset = 1;
    #1 check("async_pwm_low", 32'(pwm), 0);
    check("async_dout", d_out, 0);
    @(negedge clk);
    reset = 0;
    rd_reg(5'h00, v); check("post_ctrl", v, 0);
    rd_reg(5'h01, v); check("post_period", v, 0);
    rd_reg(5'h02, v); check("post_prescale", v, 0);
    rd_reg(5'h10, v); check("post_duty0", v, 0);
    rd_reg(5'h07, v); check("post_undecoded", v, 0);
    count_hi(0, 20, h); check("post_pwm_low", h, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/perip_pwm_multi.md
PERIP_PWM_MULTI -- requirements
Module: perip_pwm_multi

Interface
REQ-001 Parameter NCH, default 4: number of PWM channels, 1..16.
REQ-002 Parameter CW, default 16: counter, period and duty width, 8..31.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port d_in, input, 32: CPU write data.
REQ-006 Port cs, input, 1: chip select.
REQ-007 Port addr, input, 32: register address; only addr[4:0] is decoded.
REQ-008 Port rd, input, 1: register read strobe.
REQ-009 Port wr, input, 1: register write strobe.
REQ-010 Port d_out, output, 32: registered read data.
REQ-011 Port pwm, output, NCH: one PWM output per channel.

Function
REQ-012 Register map on addr[4:0]:
- 0x00 CTRL: bit0 EN, bit1 FADE.
- 0x01 PERIOD, CW bits.
- 0x02 PRESCALE, 16 bits.
- 0x03 STATUS, read-only: bit ch set when that channel's active duty differs from its target.
- 0x10+ch DUTY target for channel ch.
REQ-013 A write occurs when cs&&wr; undecoded addresses and channel indices >= NCH are ignored.
REQ-014 A read occurs when cs&&rd; d_out is loaded on the next edge, with unused bits zero and undecoded addresses returning 0.
REQ-015 d_out holds its value when no read is in progress.
REQ-016 Counter FSM has two states:
- IDLE: EN=0; prescaler and counter held at 0; all pwm low.
- RUN: EN=1.
REQ-017 Transitions: IDLE->RUN on the edge after EN is written 1; RUN->IDLE on the edge after EN is written 0; counters clear on entry to IDLE.
REQ-018 In RUN, the prescaler counts 0..PRESCALE and asserts a one-cycle tick at PRESCALE; PRESCALE=0 gives a tick every cycle.
REQ-019 On each tick, the counter increments; when the counter equals the active period it wraps to 0 (wrap event).
REQ-020 pwm[ch] = RUN && (cnt < duty_act[ch]), registered, 1-cycle latency.
REQ-021 Consequences of REQ-020: duty_act=0 gives constant low; duty_act > period gives constant high.
REQ-022 PERIOD and DUTY writes land in shadow registers; the active period and duty_act load only at a wrap event, giving glitch-free updates.
REQ-023 A write in the same cycle as a wrap updates the shadow register; the active value takes the pre-write shadow, and the new value applies at the next wrap.
REQ-024 On entry to RUN from IDLE, the active registers load immediately from the shadow registers.
REQ-025 Arithmetic is unsigned CW-bit; writes are truncated to CW bits; no counter overflow is possible because cnt <= period.

Reset
REQ-026 Reset clears CTRL, PERIOD, PRESCALE, all shadow and active duties, prescaler, counter, d_out and pwm to 0; the FSM enters IDLE.
REQ-027 Reset asserted mid-period forces all pwm low asynchronously; operation resumes only after EN is rewritten.

Configuration
REQ-028 With macro PWM_FADE_EN defined and CTRL.FADE=1, each wrap steps duty_act one count toward its target instead of loading it, and STATUS reflects the channels still fading.
REQ-029 Without PWM_FADE_EN, fade logic is absent: the FADE bit reads 0 and is ignored, and STATUS always reads 0.

Structure
REQ-030 A shared package holds the register address constants, CTRL bit positions and the FSM state typedef.
REQ-031 One sub-module, pwm_channel (duty shadow, duty_act, fade stepper, comparator), is instantiated NCH times; the timebase and bus decode stay in the top level.

Verification
REQ-032 Directed scenarios the bench covers:
- PERIOD=9, PRESCALE=0, DUTY0=3, EN=1 -> pwm[0] high 3 of every 10 cycles.
- DUTY0=0 -> pwm[0] constant low; DUTY0=12 with PERIOD=9 -> pwm[0] constant high.
- DUTY1 written 5->2 mid-period -> the current period keeps 5 high cycles; the next period has 2.
- FADE=1 (PWM_FADE_EN), DUTY0 0->4 -> duty_act increments by 1 per period, reaching 4 after 4 wraps; STATUS bit0 clears at the 4th wrap.
- Async reset mid-period -> pwm low immediately and all registers read 0; read of addr 0x07 -> d_out=0.
